alu_cmd_ctrl: RTL and testbench

- Byte-stream command controller that sequences the shared 8-bit ALU.
- Parses operand/function frames from the UART RX parallel interface and drives the ALU operand, function and enable inputs.
- Captures the registered 16-bit ALU result and returns it as two bytes, LSB first, on the UART TX parallel interface.
- Sits between the UART RX/TX pair and the ALU in the system top.

---
 rtl/alu_cmd_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command controller: parses CC A B FUN / DD FUN frames, pulses the ALU, returns its 16-bit result LSB first.
// Latency: FUN byte accepted -> ALU_EN next cycle -> TX_D_VLD rises 3 cycles after the FUN byte (with a 1-cycle ALU).
// Backpressure: TX bytes are held (data and valid) while TX_BUSY is high; RX has no backpressure, so stray bytes set RX_DROP.
//
// Ports:
//   clk, RST           clock, asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD received byte and its one-cycle strobe
//   ALU_OUT/_VALID     registered ALU result and its valid strobe
//   TX_BUSY            transmitter busy; byte accepted when TX_D_VLD=1 and TX_BUSY=0
//   ALU_A/B/FUN/EN     ALU operand, function and enable registers
//   TX_P_DATA/TX_D_VLD byte to transmit and its valid request
//   CTRL_BUSY          high whenever the controller is not idle
//   RX_DROP            sticky flag: byte arrived while no byte could be taken
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  // OUT_WIDTH must be exactly 2*DATA_WIDTH: the result goes out as two bytes.
  parameter int                    OUT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] CMD_OP     = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_REUSE  = 8'hDD
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CTRL_BUSY,
  output logic                  RX_DROP
);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_GO, ALU_WAIT, TX_LSB, TX_MSB
  } state_t;

  state_t                  state;
  // Only the upper half of the result needs keeping: the lower half is
  // loaded straight into TX_P_DATA, which holds it until accepted.
  logic [DATA_WIDTH-1:0]   res_hi;
  logic                    no_rx_state;

  // States in which an incoming byte has nowhere to go.
  assign no_rx_state = (state == ALU_GO) || (state == ALU_WAIT) ||
                       (state == TX_LSB) || (state == TX_MSB);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      res_hi    <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      ALU_EN    <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CTRL_BUSY <= 1'b0;
      RX_DROP   <= 1'b0;
    end else begin
      ALU_EN <= 1'b0;

      case (state)
        IDLE: begin
          // Unknown opcodes are ignored without flagging a drop.
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_OP) begin
              state     <= GET_A;
              CTRL_BUSY <= 1'b1;
            end else if (RX_P_DATA == CMD_REUSE) begin
              state     <= GET_FUN;
              CTRL_BUSY <= 1'b1;
            end
          end
        end

        GET_A: begin
          if (RX_D_VLD) begin
            ALU_A <= RX_P_DATA;
            state <= GET_B;
          end
        end

        GET_B: begin
          if (RX_D_VLD) begin
            ALU_B <= RX_P_DATA;
            state <= GET_FUN;
          end
        end

        GET_FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= ALU_GO;
          end
        end

        // ALU_EN is high for this one cycle; the ALU samples at the exit edge.
        ALU_GO: state <= ALU_WAIT;

        ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            res_hi    <= ALU_OUT[OUT_WIDTH-1:DATA_WIDTH];
            TX_P_DATA <= ALU_OUT[DATA_WIDTH-1:0];
            TX_D_VLD  <= 1'b1;
            state     <= TX_LSB;
          end
        end

        // TX_D_VLD is already high here, so acceptance is just !TX_BUSY.
        TX_LSB: begin
          if (!TX_BUSY) begin
            TX_P_DATA <= res_hi;
            state     <= TX_MSB;
          end
        end

        TX_MSB: begin
          if (!TX_BUSY) begin
            TX_D_VLD  <= 1'b0;
            CTRL_BUSY <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          TX_D_VLD  <= 1'b0;
          CTRL_BUSY <= 1'b0;
        end
      endcase

      if (RX_D_VLD && no_rx_state) begin
        RX_DROP <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: stub 1-cycle ALU, TX sink with optional random busy,
// frame-level reference model, vector table plus hand-written corner sequences.
module tb_alu_cmd_ctrl;

  logic        clk;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        TX_BUSY;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        CTRL_BUSY;
  logic        RX_DROP;

  alu_cmd_ctrl dut (
    .clk          (clk),
    .RST          (RST),
    .RX_P_DATA    (RX_P_DATA),
    .RX_D_VLD     (RX_D_VLD),
    .ALU_OUT      (ALU_OUT),
    .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_BUSY      (TX_BUSY),
    .ALU_A        (ALU_A),
    .ALU_B        (ALU_B),
    .ALU_FUN      (ALU_FUN),
    .ALU_EN       (ALU_EN),
    .TX_P_DATA    (TX_P_DATA),
    .TX_D_VLD     (TX_D_VLD),
    .CTRL_BUSY    (CTRL_BUSY),
    .RX_DROP      (RX_DROP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endfunction

  // ALU function table (stand-in for the real ALU).
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'h0: return {8'h0, a} + {8'h0, b};
      4'h1: return {8'h0, a} - {8'h0, b};
      4'h2: return {8'h0, a} * {8'h0, b};
      4'h3: return (b == 8'h0) ? 16'h0 : {8'h0, a / b};
      4'h4: return {8'h0, a & b};
      4'h5: return {8'h0, a | b};
      4'h6: return {8'h0, ~(a & b)};
      4'h7: return {8'h0, ~(a | b)};
      4'h8: return {8'h0, a ^ b};
      4'h9: return {8'h0, ~(a ^ b)};
      4'hA: return {15'h0, a == b};
      4'hB: return {15'h0, a > b};
      4'hC: return {15'h0, a < b};
      4'hD: return {8'h0, a >> 1};
      4'hE: return {8'h0, a} << 1;
      default: return 16'h0;
    endcase
  endfunction

  // Stub ALU: registered result, valid one cycle after enable.
  logic alu_vld;
  logic inj_vld;
  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      alu_vld <= 1'b0;
      ALU_OUT <= 16'h0;
    end else begin
      alu_vld <= ALU_EN;
      if (ALU_EN) ALU_OUT <= alu_f(ALU_A, ALU_B, ALU_FUN);
    end
  end
  assign ALU_OUT_VALID = alu_vld | inj_vld;

  // TX sink / monitor, sampled on the falling edge.
  logic [7:0] tx_q[$];
  int         acc_cnt = 0;
  int         en_cnt = 0;
  int         vld_cyc = 0;
  bit         prev_pend = 0;
  logic [7:0] prev_dat = 8'h0;
  always @(negedge clk) begin
    if (!RST) begin
      prev_pend = 0;
    end else begin
      if (prev_pend) check("tx_hold", 32'({TX_D_VLD, TX_P_DATA}), 32'({1'b1, prev_dat}));
      prev_pend = TX_D_VLD && TX_BUSY;
      prev_dat  = TX_P_DATA;
      if (TX_D_VLD && !TX_BUSY) begin
        tx_q.push_back(TX_P_DATA);
        acc_cnt++;
      end
      if (ALU_EN) en_cnt++;
      if (TX_D_VLD) vld_cyc++;
    end
  end

  bit busy_rand = 0;
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_rand) TX_BUSY = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: stored operands.
  logic [7:0] m_a = 8'h0;
  logic [7:0] m_b = 8'h0;
  int         max_gap = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, max_gap)) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic get_tx(input string nm, output logic [7:0] b, output bit ok);
    ok = 0;
    b  = 8'h0;
    for (int i = 0; i < 500; i++) begin
      if (tx_q.size() != 0) begin
        b  = tx_q.pop_front();
        ok = 1;
        return;
      end
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL %s_timeout: got no TX byte, want one within 500 cycles", nm);
  endtask

  task automatic run_frame(input string nm, input bit reuse, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] fb, input logic [15:0] exp);
    logic [7:0] lo, hi;
    bit ok;
    if (!reuse) begin
      gap(); send_byte(8'hCC);
      gap(); send_byte(a);
      gap(); send_byte(b);
      m_a = a;
      m_b = b;
    end else begin
      gap(); send_byte(8'hDD);
    end
    gap(); send_byte(fb);
    // One cycle after the FUN byte: ALU_GO.
    check({nm, "_en"}, 32'({ALU_EN, ALU_A, ALU_B, ALU_FUN}), 32'({1'b1, m_a, m_b, fb[3:0]}));
    get_tx(nm, lo, ok);
    if (ok) check({nm, "_lsb"}, 32'(lo), 32'(exp[7:0]));
    get_tx(nm, hi, ok);
    if (ok) begin
      check({nm, "_msb"}, 32'(hi), 32'(exp[15:8]));
      check({nm, "_idle"}, 32'({CTRL_BUSY, TX_D_VLD}), 32'(0));
    end
  endtask

  typedef struct {
    bit         reuse;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] fb;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t vt[9];
    logic [7:0] lo, hi;
    bit ok;
    int c0, c1, c2;

    vt[0] = '{1'b1, 8'h00, 8'h00, 8'h09, 16'h00FF};  // reuse straight after reset: A=B=0
    vt[1] = '{1'b0, 8'h05, 8'h03, 8'h00, 16'h0008};
    vt[2] = '{1'b0, 8'h10, 8'h20, 8'h02, 16'h0200};
    vt[3] = '{1'b1, 8'h00, 8'h00, 8'h01, 16'hFFF0};  // reuses 10/20
    vt[4] = '{1'b0, 8'h09, 8'h02, 8'hF3, 16'h0004};  // upper nibble of FUN discarded
    vt[5] = '{1'b1, 8'h00, 8'h00, 8'h08, 16'h000B};
    vt[6] = '{1'b0, 8'h07, 8'h02, 8'h0E, 16'h000E};
    vt[7] = '{1'b0, 8'hC8, 8'h64, 8'h00, 16'h012C};
    vt[8] = '{1'b0, 8'hFF, 8'hFF, 8'h02, 16'hFE01};

    RST = 1'b0;
    RX_P_DATA = 8'h0;
    RX_D_VLD = 1'b0;
    inj_vld = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY, RX_DROP}, 32'h0);
    RST = 1'b1;
    tick();

    // Garbage in IDLE plus a stray ALU valid: nothing must happen.
    c0 = en_cnt; c1 = vld_cyc;
    send_byte(8'h00);
    send_byte(8'hFF);
    inj_vld = 1'b1;
    send_byte(8'h12);
    inj_vld = 1'b0;
    repeat (5) tick();
    check("garbage_en", 32'(en_cnt), 32'(c0));
    check("garbage_txvld", 32'(vld_cyc), 32'(c1));
    check("garbage_flags", 32'({RX_DROP, CTRL_BUSY}), 32'(0));

    // Table vectors with a randomly busy transmitter.
    busy_rand = 1;
    max_gap = 2;
    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("vec%0d", i), vt[i].reuse, vt[i].a, vt[i].b, vt[i].fb, vt[i].exp);
    end
    busy_rand = 0;
    max_gap = 0;
    TX_BUSY = 1'b0;
    tick();

    // TX_BUSY held for 20 cycles while the LSB waits.
    TX_BUSY = 1'b1;
    c0 = acc_cnt;
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    m_a = 8'h05; m_b = 8'h03;
    for (int i = 0; i < 10 && !TX_D_VLD; i++) tick();
    for (int i = 0; i < 20; i++) begin
      check("hold_lsb", 32'({TX_D_VLD, TX_P_DATA}), 32'({1'b1, 8'h08}));
      tick();
    end
    check("hold_no_accept", 32'(acc_cnt), 32'(c0));
    TX_BUSY = 1'b0;
    get_tx("hold", lo, ok);
    if (ok) check("hold_lsb_val", 32'(lo), 32'h08);
    get_tx("hold", hi, ok);
    if (ok) check("hold_msb_val", 32'(hi), 32'h00);
    repeat (3) tick();
    check("hold_accepts", 32'(acc_cnt - c0), 32'd2);

    // Stray byte in ALU_WAIT, and first-result latency.
    check("drop_clear", 32'(RX_DROP), 32'(0));
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    check("stray_go", 32'({ALU_EN, TX_D_VLD, CTRL_BUSY}), 32'(3'b101));
    tick();
    check("stray_wait", 32'({ALU_EN, TX_D_VLD, CTRL_BUSY}), 32'(3'b001));
    send_byte(8'h55);
    check("latency3", 32'({TX_D_VLD, TX_P_DATA}), 32'({1'b1, 8'h08}));
    check("drop_set", 32'(RX_DROP), 32'(1));
    get_tx("stray", lo, ok);
    if (ok) check("stray_lsb", 32'(lo), 32'h08);
    get_tx("stray", hi, ok);
    if (ok) check("stray_msb", 32'(hi), 32'h00);
    run_frame("after_stray", 1'b0, 8'h07, 8'h02, 8'h0E, 16'h000E);
    check("drop_sticky", 32'(RX_DROP), 32'(1));

    // Reset in the middle of a frame (in GET_B).
    send_byte(8'hCC); send_byte(8'h05);
    c2 = acc_cnt;
    RST = 1'b0;
    #1;
    check("midreset_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY, RX_DROP}, 32'h0);
    repeat (2) tick();
    RST = 1'b1;
    m_a = 8'h0; m_b = 8'h0;
    repeat (4) tick();
    check("midreset_no_tx", 32'(acc_cnt), 32'(c2));
    run_frame("post_reset", 1'b0, 8'h02, 8'h02, 8'h0A, 16'h0001);

    // Randomised frames against the model.
    busy_rand = 1;
    max_gap = 2;
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb, rf, g;
      bit         reuse;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rf = 8'($urandom_range(0, 255));
      reuse = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hCC || g == 8'hDD) g = 8'h3C;
        send_byte(g);
      end
      run_frame($sformatf("rnd%0d", i), reuse, ra, rb, rf,
                alu_f(reuse ? m_a : ra, reuse ? m_b : rb, rf[3:0]));
    end
    busy_rand = 0;
    TX_BUSY = 1'b0;
    repeat (3) tick();
    check("final_flags", 32'({RX_DROP, CTRL_BUSY, TX_D_VLD}), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
